// File: rtl/text_grid_if.sv
// text_grid_if: character/command stream into the text grid.
// Master drives codes, slave returns ready.
interface text_grid_if #(
  parameter int CHAR_W = 5
);
  logic              char_valid_in;
  logic [CHAR_W-1:0] char_in;
  logic              char_ready_out;

  modport master (
    output char_valid_in,
    output char_in,
    input  char_ready_out
  );

  modport slave (
    input  char_valid_in,
    input  char_in,
    output char_ready_out
  );
endinterface

// File: rtl/text_grid_ctrl.sv
// text_grid_ctrl: circular text buffer with cursor, scrolling and blink;
// maps the raster to a character code plus in-cell pixel offsets.
module text_grid_ctrl #(
  parameter int COLS         = 32,
  parameter int ROWS         = 16,
  parameter int BUF_ROWS     = 64,
  parameter int CHAR_W       = 5,
  parameter int CELL_W       = 40,
  parameter int CELL_H       = 45,
  parameter int NL_CODE      = 31,
  parameter int BS_CODE      = 30,
  parameter int CLR_CODE     = 29,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk_in,
  input  logic              rst_in,
  text_grid_if.slave        host,
  input  logic              new_frame_in,
  input  logic [1:0]        scroll_dir_in,
  input  logic              follow_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic [CHAR_W-1:0] char_out,
  output logic [5:0]        cell_x_out,
  output logic [5:0]        cell_y_out,
  output logic              cell_valid_out,
  output logic              cursor_on_out
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(BUF_ROWS);
  localparam int LN_W  = ROW_W + 1;
  localparam int AW    = ROW_W + COL_W;
  localparam int CNT_W = 7;
  localparam int BL_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [CHAR_W-1:0] NL  = CHAR_W'(NL_CODE);
  localparam logic [CHAR_W-1:0] BS  = CHAR_W'(BS_CODE);
  localparam logic [CHAR_W-1:0] CLR = CHAR_W'(CLR_CODE);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [AW-1:0]     ADDR_MAX = AW'(BUF_ROWS * COLS - 1);
  localparam logic [LN_W-1:0]   LN_FULL  = LN_W'(BUF_ROWS);
  localparam logic [LN_W-1:0]   LN_ONE   = LN_W'(1);
  localparam logic [LN_W-1:0]   LN_VIS   = LN_W'(ROWS);
  localparam logic [5:0]        PX_MAX   = 6'(CELL_W - 1);
  localparam logic [5:0]        PY_MAX   = 6'(CELL_H - 1);
  localparam logic [BL_W-1:0]   BL_MAX   = BL_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic [AW-1:0]     clr_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [LN_W-1:0]   lines_q;
  logic [LN_W-1:0]   off_q;
  logic [LN_W-1:0]   max_off;
  logic [BL_W-1:0]   blink_q;
  logic              phase_q;

  logic              xfer;
  logic              is_nl;
  logic              is_bs;
  logic              is_clr;
  logic              clr_done;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [CHAR_W-1:0] wdata;

  logic [CHAR_W-1:0] mem [BUF_ROWS*COLS];
  logic [CHAR_W-1:0] rdata_q;

  logic [5:0]        px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0]  cc_q, cc_d, cr_q, cr_d;
  logic [ROW_W-1:0]  oldest;
  logic [ROW_W-1:0]  brow;
  logic [AW-1:0]     raddr_q;
  logic [5:0]        px2_q, py2_q, px3_q, py3_q;
  logic              val2_q, hit2_q, val3_q, hit3_q;

  assign host.char_ready_out = ready_q;
  assign xfer     = host.char_valid_in && ready_q;
  assign is_nl    = host.char_in == NL;
  assign is_bs    = host.char_in == BS;
  assign is_clr   = host.char_in == CLR;
  assign clr_done = (state_q == CLR_ALL) && (clr_q == ADDR_MAX);
  assign max_off  = (lines_q > LN_VIS) ? lines_q - LN_VIS : '0;

  always_comb begin
    we    = 1'b0;
    waddr = {row_q, col_q};
    wdata = '0;
    case (state_q)
      CLR_ROW: begin
        we    = 1'b1;
        waddr = {row_q, clr_q[COL_W-1:0]};
      end
      CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_q;
      end
      default: begin
        if (xfer && !is_clr && !is_nl) begin
          if (!is_bs) begin
            we    = 1'b1;
            wdata = host.char_in;
          end else if (col_q != '0) begin
            we    = 1'b1;
            waddr = {row_q, col_q - COL_W'(1)};
          end else if (lines_q > LN_ONE) begin
            we    = 1'b1;
            waddr = {row_q - ROW_W'(1), COL_MAX};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= CLR_ALL;
      ready_q <= 1'b0;
      clr_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      lines_q <= LN_ONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (is_clr) begin
              state_q <= CLR_ALL;
              ready_q <= 1'b0;
              clr_q   <= '0;
            end else if (is_bs) begin
              if (col_q != '0) begin
                col_q <= col_q - COL_W'(1);
              end else if (lines_q > LN_ONE) begin
                row_q <= row_q - ROW_W'(1);
                col_q <= COL_MAX;
                if (lines_q != LN_FULL) lines_q <= lines_q - LN_ONE;
              end
            end else if (is_nl || col_q == COL_MAX) begin
              col_q   <= '0;
              row_q   <= row_q + ROW_W'(1);
              if (lines_q != LN_FULL) lines_q <= lines_q + LN_ONE;
              state_q <= CLR_ROW;
              ready_q <= 1'b0;
              clr_q   <= '0;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        CLR_ROW: begin
          clr_q <= clr_q + AW'(1);
          if (clr_q[COL_W-1:0] == COL_MAX) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        CLR_ALL: begin
          clr_q <= clr_q + AW'(1);
          if (clr_done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            lines_q <= LN_ONE;
          end
        end
        default: begin
          state_q <= CLR_ALL;
          ready_q <= 1'b0;
          clr_q   <= '0;
        end
      endcase
    end
  end

  // view offset counts lines from the oldest stored line
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      off_q <= '0;
    end else if (clr_done) begin
      off_q <= '0;
    end else if (new_frame_in) begin
      if (follow_in) begin
        off_q <= max_off;
      end else if (scroll_dir_in == 2'd1) begin
        if (off_q != '0) off_q <= off_q - LN_ONE;
      end else if (scroll_dir_in == 2'd2) begin
        if (off_q < max_off) off_q <= off_q + LN_ONE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (new_frame_in) begin
      if (blink_q == BL_MAX) begin
        blink_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        blink_q <= blink_q + BL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr_q];
  end

  always_comb begin
    px_d = px_q;
    cc_d = cc_q;
    py_d = py_q;
    cr_d = cr_q;
    if (hcount_in == '0) begin
      px_d = '0;
      cc_d = '0;
    end else if (px_q == PX_MAX) begin
      px_d = '0;
      if (cc_q != '1) cc_d = cc_q + CNT_W'(1);
    end else begin
      px_d = px_q + 6'd1;
    end
    if (vcount_in == '0) begin
      py_d = '0;
      cr_d = '0;
    end else if (hcount_in == '0) begin
      if (py_q == PY_MAX) begin
        py_d = '0;
        if (cr_q != '1) cr_d = cr_q + CNT_W'(1);
      end else begin
        py_d = py_q + 6'd1;
      end
    end
  end

  assign oldest = row_q - lines_q[ROW_W-1:0] + ROW_W'(1);
  assign brow   = oldest + off_q[ROW_W-1:0] + ROW_W'(cr_q);

  // counters -> address -> RAM read -> output register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      px_q           <= '0;
      py_q           <= '0;
      cc_q           <= '0;
      cr_q           <= '0;
      raddr_q        <= '0;
      px2_q          <= '0;
      py2_q          <= '0;
      val2_q         <= 1'b0;
      hit2_q         <= 1'b0;
      px3_q          <= '0;
      py3_q          <= '0;
      val3_q         <= 1'b0;
      hit3_q         <= 1'b0;
      char_out       <= '0;
      cell_x_out     <= '0;
      cell_y_out     <= '0;
      cell_valid_out <= 1'b0;
      cursor_on_out  <= 1'b0;
    end else begin
      px_q           <= px_d;
      py_q           <= py_d;
      cc_q           <= cc_d;
      cr_q           <= cr_d;
      raddr_q        <= {brow, COL_W'(cc_q)};
      px2_q          <= px_q;
      py2_q          <= py_q;
      val2_q         <= (cc_q < CNT_W'(COLS)) && (cr_q < CNT_W'(ROWS));
      hit2_q         <= (brow == row_q) && (COL_W'(cc_q) == col_q);
      px3_q          <= px2_q;
      py3_q          <= py2_q;
      val3_q         <= val2_q;
      hit3_q         <= hit2_q;
      char_out       <= val3_q ? rdata_q : '0;
      cell_x_out     <= px3_q;
      cell_y_out     <= py3_q;
      cell_valid_out <= val3_q;
      cursor_on_out  <= phase_q && hit3_q && val3_q;
    end
  end
endmodule

// File: tb/tb_text_grid_ctrl.sv
// tb_text_grid_ctrl: directed checks of clear timing, cursor edits,
// raster mapping, blink and scrolling.
module tb_text_grid_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nf  = 1'b0;
  logic        fol = 1'b0;
  logic [1:0]  dir = 2'd0;
  logic [10:0] hc  = '0;
  logic [9:0]  vc  = '0;
  logic [4:0]  ch;
  logic [5:0]  cx;
  logic [5:0]  cy;
  logic        cv;
  logic        con;
  int          tests = 0;
  int          fails = 0;
  int          n;

  text_grid_if #(.CHAR_W(5)) bus ();

  text_grid_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .host          (bus),
    .new_frame_in  (nf),
    .scroll_dir_in (dir),
    .follow_in     (fol),
    .hcount_in     (hc),
    .vcount_in     (vc),
    .char_out      (ch),
    .cell_x_out    (cx),
    .cell_y_out    (cy),
    .cell_valid_out(cv),
    .cursor_on_out (con)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (bus.char_ready_out !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic send(input int c);
    int w;
    wait_rdy(w);
    if (w >= 5000) chk("send_timeout", w, 0);
    bus.char_valid_in = 1'b1;
    bus.char_in = 5'(c);
    @(posedge clk); #1;
    bus.char_valid_in = 1'b0;
  endtask

  // sweep from frame top; outputs then belong to the (v,h) sample
  task automatic look(input int v, input int h);
    for (int y = 0; y <= v; y++) begin
      for (int x = 0; x <= ((y == v) ? h + 3 : 0); x++) begin
        vc = 10'(y);
        hc = 11'(x);
        @(posedge clk); #1;
      end
    end
    hc = '0;
    vc = '0;
  endtask

  task automatic frames(input int k);
    repeat (k) begin
      nf = 1'b1;
      @(posedge clk); #1;
      nf = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.char_valid_in = 1'b0;
    bus.char_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.char_ready_out, 0);
    chk("rst_char", ch, 0);
    chk("rst_cx", cx, 0);
    chk("rst_valid", cv, 0);
    chk("rst_cursor", con, 0);
    rst = 1'b1;
    wait_rdy(n);
    chk("clr_all_len", n, 2048);

    for (int i = 0; i < 31; i++) send((i % 28) + 1);
    send(4);
    wait_rdy(n);
    chk("clr_row_len", n, 32);
    send(17);
    look(0, 0);
    chk("c00", ch, 1);
    look(0, 27 * 40);
    chk("c0_27", ch, 28);
    look(0, 31 * 40);
    chk("c0_31", ch, 4);
    look(45, 0);
    chk("c10_wrap", ch, 17);

    send(7);
    look(45, 40);
    chk("r_char", ch, 7);
    chk("r_cx", cx, 0);
    chk("r_cy", cy, 0);
    chk("r_valid", cv, 1);
    chk("r_cur", con, 0);
    look(47, 43);
    chk("r2_char", ch, 7);
    chk("r2_cx", cx, 3);
    chk("r2_cy", cy, 2);
    look(45, 80);
    chk("c12_clear", ch, 0);
    look(45, 1280);
    chk("r_offgrid", cv, 0);

    send(29);
    wait_rdy(n);
    chk("clr_cmd_len", n, 2048);
    look(0, 0);
    chk("clr_c00", ch, 0);
    look(45, 40);
    chk("clr_c11", ch, 0);

    send(5);
    look(0, 0);
    chk("bs_pre", ch, 5);
    send(30);
    send(30);
    chk("bs_ready", bus.char_ready_out, 1);
    look(0, 0);
    chk("bs_erase", ch, 0);
    send(9);
    look(0, 0);
    chk("bs_cursor", ch, 9);
    send(11);
    send(12);
    look(0, 40);
    chk("c01", ch, 11);

    frames(29);
    look(0, 120);
    chk("blink29", con, 0);
    frames(1);
    look(0, 120);
    chk("blink30", con, 1);
    look(0, 80);
    chk("blink_left", con, 0);
    look(45, 120);
    chk("blink_below", con, 0);
    frames(30);
    look(0, 120);
    chk("blink60", con, 0);

    for (int l = 1; l <= 20; l++) begin
      send(31);
      send(l);
    end
    fol = 1'b1;
    frames(1);
    fol = 1'b0;
    look(0, 0);
    chk("follow_top", ch, 5);
    look(675, 0);
    chk("follow_bot", ch, 20);
    dir = 2'd1;
    frames(10);
    dir = 2'd0;
    look(0, 0);
    chk("up_floor", ch, 9);
    look(675, 0);
    chk("up_bot", ch, 15);
    dir = 2'd2;
    frames(3);
    look(0, 0);
    chk("down3", ch, 3);
    frames(20);
    dir = 2'd0;
    look(0, 0);
    chk("down_ceil", ch, 5);

    send(30);
    send(30);
    send(13);
    look(630, 31 * 40);
    chk("bs_rowback", ch, 13);
    look(675, 0);
    chk("wrap_clear", ch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
